immediate_gen: RTL and testbench
================================

IMMEDIATE_GEN -- requirements
Module: immediate_gen

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 64, width of the sign-extended immediate output.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, qualifies instruction this cycle.
REQ-005 The block SHALL have port instruction, input, 32 bits, RV64 instruction word.
REQ-006 The block SHALL have port out_valid, output, 1 bit, imm_out and fmt_out hold a new result.
REQ-007 The block SHALL have port imm_out, output, XLEN bits, sign-extended immediate.
REQ-008 The block SHALL have port fmt_out, output, 3 bits, decoded format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.

Function
REQ-009 The block SHALL register its result with latency 1: the in_valid/instruction sampled at edge N appear on the outputs after edge N.
REQ-010 The block SHALL set out_valid to in_valid delayed by one cycle, with no backpressure.
REQ-011 The block SHALL hold imm_out and fmt_out unchanged while in_valid is low.
REQ-012 The block SHALL select the format from instruction[6:0] only.
REQ-013 The block SHALL treat opcodes 0000011, 0010011, 0011011 and 1100111 as I-type: imm = sext(instr[31:20]).
REQ-014 The block SHALL treat opcode 0100011 as S-type: imm = sext({instr[31:25], instr[11:7]}).
REQ-015 The block SHALL treat opcode 1100011 as B-type: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-016 The block SHALL treat opcodes 0110111 and 0010111 as U-type: imm = sext({instr[31:12], 12'b0}).
REQ-017 The block SHALL treat opcode 1101111 as J-type: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-018 The block SHALL output imm_out = 0 and fmt_out = NONE for any other opcode, including R-type 0110011.
REQ-019 The block SHALL sign-extend from the immediate MSB (always instr[31]) to the full XLEN bits.
REQ-020 The block SHALL decode I-type shift instructions as plain I-type, with no masking of the shamt or funct bits.

Reset
REQ-021 The block SHALL, while rst_n is low, immediately force out_valid = 0, imm_out = 0 and fmt_out = NONE, independent of clk.
REQ-022 The block SHALL ignore in_valid at the first rising edge after rst_n deasserts only if that edge coincides with the deassertion; otherwise it captures normally.
REQ-023 The block SHALL drop a transfer that is in flight when reset asserts.

Configuration
REQ-024 The block SHALL honour the macro IMM_GEN_UJ_EN: when defined, U-type and J-type are decoded per REQ-016 and REQ-017.
REQ-025 The block SHALL, with IMM_GEN_UJ_EN undefined, treat the U and J opcodes as unsupported: imm_out = 0 and fmt_out = NONE; fmt codes 4 and 5 never occur.

Structure
REQ-026 The block SHALL take its opcode constants, the fmt enumeration and XLEN default from a shared package, immediate_gen_pkg.
REQ-027 The block SHALL place the combinational format and immediate decode in one sub-module, imm_decode, with the output register in immediate_gen.

Verification
REQ-028 The bench SHALL apply instruction 32'hFFF01283 with in_valid = 1 (ld) and require, after one cycle, imm_out = 64'hFFFF_FFFF_FFFF_FFFF, fmt_out = 1, out_valid = 1.
REQ-029 The bench SHALL apply 32'hFEF02223 (sd) and require imm_out = 64'hFFFF_FFFF_FFFF_FFE4 (-28), fmt_out = 2.
REQ-030 The bench SHALL apply 32'hFEF0E063 (beq) and require imm_out = 64'hFFFF_FFFF_FFFF_F7E0 (-2080), fmt_out = 3.
REQ-031 The bench SHALL apply 32'h00A00533 (R-type) and require imm_out = 0, fmt_out = 0.
REQ-032 The bench SHALL, with IMM_GEN_UJ_EN defined, apply 32'h123450B7 (lui) and require imm_out = 64'h0000_0000_1234_5000, fmt_out = 4; with the macro undefined it SHALL require imm_out = 0, fmt_out = 0.
REQ-033 The bench SHALL assert rst_n low mid-stream with in_valid = 1 and require out_valid = 0 and imm_out = 0 immediately, before any clock edge.

Source files
------------

// File: rtl/immediate_gen_pkg.sv
// Shared opcode constants, format encoding and default datapath width for the
// RV64 immediate generator.
package immediate_gen_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

endpackage

// File: rtl/immediate_gen_imm_decode.sv
// Combinational format and immediate decode from the opcode field.
// U/J formats are decoded only when IMM_GEN_UJ_EN is defined.
module imm_decode
  import immediate_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr_i,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] imm_o
);

  fmt_e              fmt;
  logic signed [31:0] imm32;

  // Every format's MSB is instr[31], so a 32-bit signed intermediate suffices.
  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  always_comb begin
    fmt   = FMT_NONE;
    imm32 = '0;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
`ifdef IMM_GEN_UJ_EN
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
`endif
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
  end

`ifndef IMM_GEN_UJ_EN
  logic unused_uj_bits;
  assign unused_uj_bits = ^instr_i[19:12];
`endif

  assign fmt_o = fmt;
  assign imm_o = sext(imm32);

endmodule

// File: rtl/immediate_gen.sv
// RV64 immediate generator: one-cycle registered decode of format and
// sign-extended immediate. Optional U/J support via IMM_GEN_UJ_EN.
module immediate_gen
  import immediate_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt_out
);

  logic [2:0]      fmt_d;
  logic [XLEN-1:0] imm_d;

  logic            vld_q;
  logic [2:0]      fmt_q;
  logic [XLEN-1:0] imm_q;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (instruction),
    .fmt_o   (fmt_d),
    .imm_o   (imm_d)
  );

  // Output stage: data only loads on a valid beat so results hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      fmt_q <= FMT_NONE;
      imm_q <= '0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        fmt_q <= fmt_d;
        imm_q <= imm_d;
      end
    end
  end

  assign out_valid = vld_q;
  assign fmt_out   = fmt_q;
  assign imm_out   = imm_q;

endmodule

// File: tb/tb_immediate_gen.sv
// Self-checking bench for immediate_gen: directed vectors, reset behaviour and
// randomized instructions against an arithmetic reference model.
module tb_immediate_gen;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [63:0] imm_out;
  logic [2:0]  fmt_out;

  int checks = 0;
  int errors = 0;

  logic        exp_vld;
  logic [63:0] exp_imm;
  logic [2:0]  exp_fmt;

  immediate_gen #(.XLEN(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .instruction (instruction),
    .out_valid   (out_valid),
    .imm_out     (imm_out),
    .fmt_out     (fmt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: immediate value assembled by weighted field arithmetic.
  function automatic void model(input logic [31:0] ins, output logic [63:0] imm,
                                output logic [2:0] fmt);
    longint v;
    longint sgn;
    sgn = ins[31] ? 64'sd1 : 64'sd0;
    v   = 0;
    fmt = 3'd0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: begin
        fmt = 3'd1;
        v = longint'(ins[31:20]) - sgn * 4096;
      end
      7'h23: begin
        fmt = 3'd2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - sgn * 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
          + longint'(ins[11:8]) * 2 - sgn * 4096;
      end
`ifdef IMM_GEN_UJ_EN
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(ins[31:12]) * 4096 - sgn * 64'sd4294967296;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
          + longint'(ins[30:21]) * 2 - sgn * 1048576;
      end
`endif
      default: begin
        fmt = 3'd0;
        v = 0;
      end
    endcase
    imm = 64'(v);
  endfunction

  task automatic check_outputs(input string tag);
    checks++;
    assert (out_valid === exp_vld) else begin
      errors++;
      $error("FAIL %s out_valid got %b exp %b", tag, out_valid, exp_vld);
    end
    checks++;
    assert (imm_out === exp_imm) else begin
      errors++;
      $error("FAIL %s imm_out got %h exp %h", tag, imm_out, exp_imm);
    end
    checks++;
    assert (fmt_out === exp_fmt) else begin
      errors++;
      $error("FAIL %s fmt_out got %0d exp %0d", tag, fmt_out, exp_fmt);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input string tag);
    logic [63:0] mi;
    logic [2:0]  mf;
    @(negedge clk);
    in_valid    = v;
    instruction = ins;
    @(posedge clk);
    #1;
    exp_vld = v;
    if (v) begin
      model(ins, mi, mf);
      exp_imm = mi;
      exp_fmt = mf;
    end
    check_outputs(tag);
  endtask

  task automatic check_fixed(input logic [63:0] imm, input logic [2:0] fmt,
                             input string tag);
    checks++;
    assert (imm_out === imm) else begin
      errors++;
      $error("FAIL %s imm_out got %h exp %h", tag, imm_out, imm);
    end
    checks++;
    assert (fmt_out === fmt) else begin
      errors++;
      $error("FAIL %s fmt_out got %0d exp %0d", tag, fmt_out, fmt);
    end
  endtask

  logic [6:0]  opc_tab [12];
  logic [31:0] r;

  initial begin
    opc_tab = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};
    rst_n = 1'b0;
    in_valid = 1'b0;
    instruction = 32'h0;
    exp_vld = 1'b0;
    exp_imm = '0;
    exp_fmt = 3'd0;
    #1;
    check_outputs("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    step(1'b1, 32'hFFF01283, "ld");
    check_fixed(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, "ld_const");
    step(1'b1, 32'hFEF02223, "sd");
    check_fixed(64'hFFFF_FFFF_FFFF_FFE4, 3'd2, "sd_const");
    step(1'b1, 32'hFEF0E063, "beq");
    check_fixed(64'hFFFF_FFFF_FFFF_F7E0, 3'd3, "beq_const");
    step(1'b1, 32'h00A00533, "rtype");
    check_fixed(64'h0, 3'd0, "rtype_const");
    step(1'b1, 32'h123450B7, "lui");
`ifdef IMM_GEN_UJ_EN
    check_fixed(64'h0000_0000_1234_5000, 3'd4, "lui_const");
`else
    check_fixed(64'h0, 3'd0, "lui_const");
`endif
    step(1'b1, 32'h41F55513, "srai");
    check_fixed(64'h0000_0000_0000_041F, 3'd1, "srai_const");
    step(1'b1, 32'h7FF00067, "jalr_max");
    step(1'b1, 32'h8000006F, "jal_neg");
    step(1'b0, 32'hFFF01283, "hold1");
    step(1'b0, 32'h00000013, "hold2");

    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[6:0] = opc_tab[$urandom_range(0, 11)];
      step(1'($urandom_range(0, 3) != 0), r, "random");
    end

    // Reset lands mid-cycle with a new valid beat pending.
    step(1'b1, 32'hFFF01283, "pre_reset");
    @(negedge clk);
    in_valid    = 1'b1;
    instruction = 32'hFEF02223;
    #2 rst_n = 1'b0;
    #1;
    exp_vld = 1'b0;
    exp_imm = '0;
    exp_fmt = 3'd0;
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("reset_held");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_vld = 1'b1;
    model(32'hFEF02223, exp_imm, exp_fmt);
    check_outputs("post_reset_capture");
    step(1'b1, 32'hFEF0E063, "post_reset_beq");
    step(1'b0, 32'h0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
